basic_control_unit: RTL
=======================

# basic_control_unit

Hardwired sequencer that drives every control select of the ALU datapath system: the register file, address register file, ALU, IR, memory and muxes A/B/C. It fetches each 16-bit instruction as two bytes from memory into the IR, decodes it and issues per-cycle micro-operations from a T-state counter. It is the initiator side of the datapath's control interface, and its outputs connect one-to-one to the datapath's select inputs.

## Interface
- No parameters. All encodings are constants in `cu_pkg`.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset.
- `IROut` in 16: IR contents from the datapath.
- `ALU_Flags` in 4: {Z,C,N,O}.
- `RF_OutASel`, `RF_OutBSel` out 3 each: RF read selects.
- `RF_FunSel` out 3: RF function select.
- `RF_RegSel`, `RF_ScrSel` out 4 each: active-low enables; bit3=R1 … bit0=R4.
- `ALU_FunSel` out 5: ALU function select.
- `ALU_WF` out 1: ALU flag write enable.
- `ARF_OutCSel`, `ARF_OutDSel` out 2 each: ARF read selects.
- `ARF_FunSel` out 3: ARF function select.
- `ARF_RegSel` out 3: active-low enables; bit2=PC, bit1=AR, bit0=SP.
- `IR_LH` out 1: 0 loads the IR low byte, 1 loads the high byte.
- `IR_Write` out 1: IR write enable.
- `Mem_WR` out 1: 1 selects write.
- `Mem_CS` out 1: active-low chip select.
- `MuxASel`, `MuxBSel` out 2 each; `MuxCSel` out 1: mux selects.
- `SeqT` out 2: current T-state.
- `Halted` out 1: high while in HALT.

## Operation
- **Function encodings (RF and ARF):** 000 DEC, 001 INC, 010 LOAD, 011 CLR.
- **OutDSel encodings:** 00 PC, 10 AR, 11 SP.
- **ALU encodings:** A16 = 10000, ADD16 = 10100.
- **Instruction format:** [15:10] opcode, [9:8] Rd (00=R1 … 11=R4), [7:0] imm/addr. Rs = [7:6].
- **Idle values:** all RegSel/ScrSel bits = 1, `Mem_CS` = 1, and every other output = 0.
  - Any signal not listed for a T-state takes its idle value.
- **T0:** OutDSel = PC, `Mem_CS` = 0, `IR_Write` = 1, `IR_LH` = 0, ARF INC on PC.
- **T1:** same as T0 with `IR_LH` = 1.
- **T2 (execute), by opcode:**
  - 0x00 BRA: MuxB = 11, ARF LOAD on PC.
  - 0x01 BNE: same as BRA only when Z = 0; otherwise idle.
  - 0x02 LDI: MuxA = 11, RF LOAD on Rd.
  - 0x03 LDAR: MuxB = 11, ARF LOAD on AR.
  - 0x04 LD: OutDSel = AR, `Mem_CS` = 0, MuxA = 10, RF LOAD on Rd.
  - 0x05 ADD: OutASel = Rd, OutBSel = Rs, ADD16, `ALU_WF` = 1, MuxA = 00, RF LOAD on Rd.
  - 0x06 ST: OutASel = Rd, A16, MuxC = 0, OutDSel = AR, `Mem_CS` = 0, `Mem_WR` = 1, ARF INC on AR; go to T3.
  - 0x07 INC: RF INC on Rd.
  - 0x3F HLT: go to HALT.
  - Any other opcode: NOP.
- **T3 (ST only):** same as ST's T2 with MuxC = 1.

## Timing
- **Outputs:** combinational from state, `IROut` and `ALU_Flags`. While `Reset` = 0, all outputs are forced to idle values.
- **State register:** asynchronous clear to T0 (`SeqT` = 0, `Halted` = 0).
  - The first fetch (T0 outputs) is driven in the first cycle after `Reset` deasserts.
- **Transitions:**
  - T0→T1→T2 unconditionally.
  - From T2: →T3 for ST, →HALT for HLT, else →T0.
  - T3→T0.
- **HALT:** sticky until reset. Outputs are idle, `Halted` = 1, `SeqT` = 0.
- **Latency:** 3 cycles per instruction; ST takes 4.
  - The IR is complete at the T1→T2 edge, so T2 decode uses the new `IROut`.
- **BNE:** samples Z combinationally during T2. Flags written by the prior instruction's edge are visible.
- **ADD:** the RF load and flag write occur on the same edge.
- **Reset mid-instruction** (any T-state, including T3 of ST): state returns to T0 immediately. No partial second store is issued.
- **Wrap-around:** PC and AR wrap at 16 bits; this is inherited from the ARF and no check is made here.

## Structure
- **`cu_pkg`:**
  - T-state enum {T0, T1, T2, T3, HALT}.
  - Opcode constants.
  - FunSel, ALU, OutDSel and mux constants.
  - Idle-value constants.
  - Rd→active-low RegSel decode function.
- **Sub-module `cu_seq`:** state register and next-state logic.
- **Top level:** output decode only.

## Test plan
- **Reset then fetch:** hold `Reset` = 0 for 3 cycles → all outputs idle. Release → T0 has `IR_Write` = 1, `IR_LH` = 0, `ARF_RegSel` = 011, `ARF_FunSel` = 001. T1 has `IR_LH` = 1.
- **LDI:** `IROut` = 0x0A5C in T2 (0x02, R3) → `MuxASel` = 11, `RF_FunSel` = 010, `RF_RegSel` = 1101. `SeqT` = 0 next cycle.
- **BNE:**
  - `IROut` = 0x0440 with Z = 1 → idle outputs in T2.
  - Same with Z = 0 → `MuxBSel` = 11, `ARF_RegSel` = 011, `ARF_FunSel` = 010.
- **ST:** `IROut` = 0x1900 (0x06, R2) → T2 and T3 both have `Mem_WR` = 1, `Mem_CS` = 0, `ARF_OutDSel` = 10, `ARF_RegSel` = 101, INC. `MuxCSel` is 0 then 1; `SeqT` reaches 3.
- **Reset during ST T3:** drop `Reset` → outputs idle in the same cycle. After release, T0 fetch; no MuxC = 1 write occurs.
- **Halt and undefined opcodes:**
  - `IROut` = 0xFC00 → `Halted` = 1 and outputs idle for 10 cycles.
  - Opcode 0x10 → NOP in T2, then back to T0.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings, T-state type and select helpers for the control unit
//
// Purpose: single home for every encoding the control unit drives onto the
// datapath: T-states, opcodes, RF/ARF function codes, ALU codes, OutDSel and
// mux codes, idle values, and the Rd -> active-low RegSel decode.
// Ports: none (package).

package cu_pkg;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } tstate_t;

    // Opcodes (IR[15:10])
    localparam logic [5:0] OP_BRA  = 6'h00;
    localparam logic [5:0] OP_BNE  = 6'h01;
    localparam logic [5:0] OP_LDI  = 6'h02;
    localparam logic [5:0] OP_LDAR = 6'h03;
    localparam logic [5:0] OP_LD   = 6'h04;
    localparam logic [5:0] OP_ADD  = 6'h05;
    localparam logic [5:0] OP_ST   = 6'h06;
    localparam logic [5:0] OP_INC  = 6'h07;
    localparam logic [5:0] OP_HLT  = 6'h3F;

    // RF and ARF function codes
    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // ALU function codes
    localparam logic [4:0] ALU_A16   = 5'b10000;
    localparam logic [4:0] ALU_ADD16 = 5'b10100;

    // ARF OutD selects
    localparam logic [1:0] OUTD_PC = 2'b00;
    localparam logic [1:0] OUTD_AR = 2'b10;
    localparam logic [1:0] OUTD_SP = 2'b11;

    // Active-low ARF register enables: bit2=PC, bit1=AR, bit0=SP
    localparam logic [2:0] ARF_SEL_PC = 3'b011;
    localparam logic [2:0] ARF_SEL_AR = 3'b101;
    localparam logic [2:0] ARF_SEL_SP = 3'b110;

    // Mux selects
    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b10;
    localparam logic [1:0] MUXA_IMM = 2'b11;
    localparam logic [1:0] MUXB_IMM = 2'b11;

    // Idle values
    localparam logic [3:0] IDLE_REGSEL  = 4'b1111;
    localparam logic [2:0] IDLE_ARF_SEL = 3'b111;
    localparam logic       IDLE_MEM_CS  = 1'b1;

    // Rd (00=R1 .. 11=R4) to active-low RegSel with bit3=R1 .. bit0=R4
    function automatic logic [3:0] regsel_dec(input logic [1:0] rd);
        return ~(4'b1000 >> rd);
    endfunction

endpackage

// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - T-state register and next-state logic of the control unit
//
// Purpose: T0 -> T1 -> T2 -> (T3 for ST | HALT for HLT | T0); T3 -> T0;
// HALT holds until reset.
// Ports:
//   Clock  in  rising-edge clock
//   Reset  in  asynchronous active-low reset, clears to T0
//   opcode in  IR[15:10], only consulted in T2
//   state  out current T-state

module cu_seq
    import cu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] opcode,
    output tstate_t    state
);

    tstate_t state_next;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            T0:   state_next = T1;
            T1:   state_next = T2;
            T2: begin
                if (opcode == OP_ST) begin
                    state_next = T3;
                end else if (opcode == OP_HLT) begin
                    state_next = HALT;
                end else begin
                    state_next = T0;
                end
            end
            T3:   state_next = T0;
            HALT: state_next = HALT;
            default: state_next = T0;
        endcase
    end

endmodule

// File: rtl/basic_control_unit.sv
// rtl/basic_control_unit.sv - hardwired sequencer driving the ALU datapath selects
//
// Purpose: fetches a 16-bit instruction as two bytes into the IR (T0, T1),
// decodes it in T2 (plus T3 for ST) and drives every datapath select.
// Ports:
//   Clock, Reset                       clock, async active-low reset
//   IROut[15:0], ALU_Flags[3:0]        IR contents, {Z,C,N,O}
//   RF_OutASel/OutBSel/FunSel[2:0]     RF read selects and function
//   RF_RegSel/ScrSel[3:0]              RF active-low enables
//   ALU_FunSel[4:0], ALU_WF            ALU function, flag write enable
//   ARF_OutCSel/OutDSel[1:0]           ARF read selects
//   ARF_FunSel[2:0], ARF_RegSel[2:0]   ARF function, active-low enables
//   IR_LH, IR_Write                    IR byte select, IR write enable
//   Mem_WR, Mem_CS                     memory write select, active-low CS
//   MuxASel/MuxBSel[1:0], MuxCSel      datapath mux selects
//   SeqT[1:0], Halted                  current T-state, halt indicator

module basic_control_unit
    import cu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [1:0]  SeqT,
    output logic        Halted
);

    tstate_t    state;
    logic [5:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       flag_z;
    logic       unused_inputs;

    assign opcode        = IROut[15:10];
    assign rd            = IROut[9:8];
    assign rs            = IROut[7:6];
    assign flag_z        = ALU_Flags[3];
    assign unused_inputs = ^{IROut[5:0], ALU_Flags[2:0]};

    cu_seq u_seq (
        .Clock  (Clock),
        .Reset  (Reset),
        .opcode (opcode),
        .state  (state)
    );

    // Reset gates everything to idle even though the state is already T0,
    // so the T0 fetch never leaks out while Reset is held low.
    always_comb begin
        RF_OutASel  = '0;
        RF_OutBSel  = '0;
        RF_FunSel   = '0;
        RF_RegSel   = IDLE_REGSEL;
        RF_ScrSel   = IDLE_REGSEL;
        ALU_FunSel  = '0;
        ALU_WF      = 1'b0;
        ARF_OutCSel = '0;
        ARF_OutDSel = '0;
        ARF_FunSel  = '0;
        ARF_RegSel  = IDLE_ARF_SEL;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = IDLE_MEM_CS;
        MuxASel     = '0;
        MuxBSel     = '0;
        MuxCSel     = 1'b0;
        SeqT        = 2'd0;
        Halted      = 1'b0;
        if (Reset) begin
            case (state)
                T0, T1: begin
                    SeqT        = (state == T1) ? 2'd1 : 2'd0;
                    ARF_OutDSel = OUTD_PC;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (state == T1);
                    ARF_FunSel  = FUN_INC;
                    ARF_RegSel  = ARF_SEL_PC;
                end
                T2: begin
                    SeqT = 2'd2;
                    case (opcode)
                        OP_BRA, OP_BNE: begin
                            if (opcode == OP_BRA || !flag_z) begin
                                MuxBSel    = MUXB_IMM;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = ARF_SEL_PC;
                            end
                        end
                        OP_LDI: begin
                            MuxASel   = MUXA_IMM;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = regsel_dec(rd);
                        end
                        OP_LDAR: begin
                            MuxBSel    = MUXB_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_SEL_AR;
                        end
                        OP_LD: begin
                            ARF_OutDSel = OUTD_AR;
                            Mem_CS      = 1'b0;
                            MuxASel     = MUXA_MEM;
                            RF_FunSel   = FUN_LOAD;
                            RF_RegSel   = regsel_dec(rd);
                        end
                        OP_ADD: begin
                            RF_OutASel = {1'b0, rd};
                            RF_OutBSel = {1'b0, rs};
                            ALU_FunSel = ALU_ADD16;
                            ALU_WF     = 1'b1;
                            MuxASel    = MUXA_ALU;
                            RF_FunSel  = FUN_LOAD;
                            RF_RegSel  = regsel_dec(rd);
                        end
                        OP_ST: begin
                            RF_OutASel  = {1'b0, rd};
                            ALU_FunSel  = ALU_A16;
                            MuxCSel     = 1'b0;
                            ARF_OutDSel = OUTD_AR;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                            ARF_FunSel  = FUN_INC;
                            ARF_RegSel  = ARF_SEL_AR;
                        end
                        OP_INC: begin
                            RF_FunSel = FUN_INC;
                            RF_RegSel = regsel_dec(rd);
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    // Second store byte: same as ST's T2 but the upper mux half.
                    SeqT        = 2'd3;
                    RF_OutASel  = {1'b0, rd};
                    ALU_FunSel  = ALU_A16;
                    MuxCSel     = 1'b1;
                    ARF_OutDSel = OUTD_AR;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b1;
                    ARF_FunSel  = FUN_INC;
                    ARF_RegSel  = ARF_SEL_AR;
                end
                HALT: Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
